// File: rtl/exec_pkg.sv
// Shared types for the execute stage: ALU opcode encoding, iterative
// mul/div FSM states and the multi-cycle opcode classifier.
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_MUL   = 4'd10,
        ALU_MULHU = 4'd11,
        ALU_DIVU  = 4'd12,
        ALU_REMU  = 4'd13
    } alu_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    function automatic logic is_multicycle(input alu_op_t op);
        case (op)
            ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiplier / divider: one bit per cycle over W cycles,
// shift-add for MUL/MULHU and restoring division for DIVU/REMU.
module muldiv_iter
    import exec_pkg::*;
#(
    parameter int W = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  alu_op_t       op,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 32'sd1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    md_state_t       state_r;
    md_state_t       stateNext_s;
    logic [CW-1:0]   cnt_r;
    alu_op_t         op_r;
    logic [W-1:0]    opnd_r;
    logic [2*W-1:0]  acc_r;

    logic            isDiv_s;
    logic [W:0]      mulSum_s;
    logic [2*W-1:0]  mulNext_s;
    logic [W:0]      divHi_s;
    logic [W-1:0]    divDiff_s;
    logic [2*W-1:0]  divNext_s;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= MD_IDLE;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        stateNext_s = MD_IDLE;
        case (state_r)
            MD_IDLE: begin
                if (start) begin
                    stateNext_s = MD_BUSY;
                end else begin
                    stateNext_s = MD_IDLE;
                end
            end
            MD_BUSY: begin
                if (cnt_r == CNT_LAST) begin
                    stateNext_s = MD_DONE;
                end else begin
                    stateNext_s = MD_BUSY;
                end
            end
            MD_DONE: stateNext_s = MD_IDLE;
            default: stateNext_s = MD_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_r)
            MD_BUSY: busy = 1'b1;
            MD_DONE: done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // One iteration step: acc holds {partial, multiplier} or {remainder, quotient}
    always_comb begin
        isDiv_s   = (op_r == ALU_DIVU) || (op_r == ALU_REMU);
        mulSum_s  = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, opnd_r} : {(W+1){1'b0}});
        mulNext_s = {mulSum_s, acc_r[W-1:1]};
        divHi_s   = acc_r[2*W-1:W-1];
        divDiff_s = divHi_s[W-1:0] - opnd_r;
        if (divHi_s >= {1'b0, opnd_r}) begin
            divNext_s = {divDiff_s, acc_r[W-2:0], 1'b1};
        end else begin
            divNext_s = {divHi_s[W-1:0], acc_r[W-2:0], 1'b0};
        end
    end

    // Operand latch, accumulator and iteration counter
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r  <= {(2*W){1'b0}};
            opnd_r <= {W{1'b0}};
            op_r   <= ALU_ADD;
            cnt_r  <= {CW{1'b0}};
        end else if ((state_r == MD_IDLE) && start) begin
            op_r  <= op;
            cnt_r <= {CW{1'b0}};
            if ((op == ALU_DIVU) || (op == ALU_REMU)) begin
                acc_r  <= {{W{1'b0}}, a};
                opnd_r <= b;
            end else begin
                acc_r  <= {{W{1'b0}}, b};
                opnd_r <= a;
            end
        end else if (state_r == MD_BUSY) begin
            acc_r <= isDiv_s ? divNext_s : mulNext_s;
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            acc_r <= acc_r;
        end
    end

    // Select the requested half of the accumulator
    always_comb begin
        result = {W{1'b0}};
        case (op_r)
            ALU_MUL:   result = acc_r[W-1:0];
            ALU_MULHU: result = acc_r[2*W-1:W];
            ALU_DIVU:  result = acc_r[W-1:0];
            ALU_REMU:  result = acc_r[2*W-1:W];
            default:   result = {W{1'b0}};
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute pipeline stage: combinational ALU, iterative mul/div with upstream
// stall, and the registered EX/MEM boundary.
module execute_stage
    import exec_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inValid,
    input  alu_op_t                   aluOp,
    input  logic [BUS_DATA_WIDTH-1:0] operandA,
    input  logic [BUS_DATA_WIDTH-1:0] operandB,
    input  logic [BUS_DATA_WIDTH-1:0] inWriteData,
    input  logic [5:0]                inWriteRegister,
    input  logic                      inRegWrite,
    input  logic                      inMemOrReg,
    input  logic                      inMemRead,
    input  logic                      inMemWrite,
    input  logic                      inBranch,
    output logic                      stall,
    output logic                      outValid,
    output logic [BUS_DATA_WIDTH-1:0] addressOrAluData,
    output logic [BUS_DATA_WIDTH-1:0] writeData,
    output logic [5:0]                outWriteRegister,
    output logic                      outRegWrite,
    output logic                      outMemOrReg,
    output logic                      memRead,
    output logic                      memWrite,
    output logic                      outBranch,
    output logic                      zeroSignal
);

    localparam int W   = BUS_DATA_WIDTH;
    localparam int SHW = $clog2(W);

    logic [SHW-1:0] shamt_s;
    logic [W-1:0]   aluResult_s;
    logic [W-1:0]   result_s;
    logic [W-1:0]   mdResult_s;
    logic           mdBusy_s;
    logic           mdDone_s;
    logic           mdStart_s;
    logic           accept_s;

    assign shamt_s = operandB[SHW-1:0];

    // Single-cycle ALU
    always_comb begin
        aluResult_s = {W{1'b0}};
        case (aluOp)
            ALU_ADD:  aluResult_s = operandA + operandB;
            ALU_SUB:  aluResult_s = operandA - operandB;
            ALU_AND:  aluResult_s = operandA & operandB;
            ALU_OR:   aluResult_s = operandA | operandB;
            ALU_XOR:  aluResult_s = operandA ^ operandB;
            ALU_SLL:  aluResult_s = operandA << shamt_s;
            ALU_SRL:  aluResult_s = operandA >> shamt_s;
            ALU_SRA:  aluResult_s = $unsigned($signed(operandA) >>> shamt_s);
            ALU_SLT:  aluResult_s = {{(W-1){1'b0}}, ($signed(operandA) < $signed(operandB))};
            ALU_SLTU: aluResult_s = {{(W-1){1'b0}}, (operandA < operandB)};
            default:  aluResult_s = {W{1'b0}};
        endcase
    end

    muldiv_iter #(.W(W)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (mdStart_s),
        .op     (aluOp),
        .a      (operandA),
        .b      (operandB),
        .busy   (mdBusy_s),
        .done   (mdDone_s),
        .result (mdResult_s)
    );

    // Stall from the first presentation of a mul/div until its DONE cycle
    always_comb begin
        mdStart_s = inValid && is_multicycle(aluOp) && !mdBusy_s && !mdDone_s;
        stall     = !reset && (mdStart_s || mdBusy_s);
        accept_s  = inValid && !stall;
        if (is_multicycle(aluOp)) begin
            result_s = mdResult_s;
        end else begin
            result_s = aluResult_s;
        end
    end

    // EX/MEM boundary register; bubbles clear the side-effecting controls only
    always_ff @(posedge clk) begin
        if (reset) begin
            outValid         <= 1'b0;
            addressOrAluData <= {W{1'b0}};
            writeData        <= {W{1'b0}};
            outWriteRegister <= 6'd0;
            outRegWrite      <= 1'b0;
            outMemOrReg      <= 1'b0;
            memRead          <= 1'b0;
            memWrite         <= 1'b0;
            outBranch        <= 1'b0;
            zeroSignal       <= 1'b0;
        end else if (accept_s) begin
            outValid         <= 1'b1;
            addressOrAluData <= result_s;
            writeData        <= inWriteData;
            outWriteRegister <= inWriteRegister;
            outRegWrite      <= inRegWrite;
            outMemOrReg      <= inMemOrReg;
            memRead          <= inMemRead;
            memWrite         <= inMemWrite;
            outBranch        <= inBranch;
            zeroSignal       <= (result_s == {W{1'b0}});
        end else begin
            outValid    <= 1'b0;
            outRegWrite <= 1'b0;
            memRead     <= 1'b0;
            memWrite    <= 1'b0;
            outBranch   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage: single-cycle ALU ops, iterative
// mul/div latency and results, reset abort and store bubbles.
module tb_execute_stage;
    import exec_pkg::*;

    logic        clk;
    logic        reset;
    logic        inValid;
    alu_op_t     aluOp;
    logic [63:0] operandA;
    logic [63:0] operandB;
    logic [63:0] inWriteData;
    logic [5:0]  inWriteRegister;
    logic        inRegWrite;
    logic        inMemOrReg;
    logic        inMemRead;
    logic        inMemWrite;
    logic        inBranch;
    logic        stall;
    logic        outValid;
    logic [63:0] addressOrAluData;
    logic [63:0] writeData;
    logic [5:0]  outWriteRegister;
    logic        outRegWrite;
    logic        outMemOrReg;
    logic        memRead;
    logic        memWrite;
    logic        outBranch;
    logic        zeroSignal;

    int compared;
    int mismatched;

    execute_stage #(.BUS_DATA_WIDTH(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .inValid          (inValid),
        .aluOp            (aluOp),
        .operandA         (operandA),
        .operandB         (operandB),
        .inWriteData      (inWriteData),
        .inWriteRegister  (inWriteRegister),
        .inRegWrite       (inRegWrite),
        .inMemOrReg       (inMemOrReg),
        .inMemRead        (inMemRead),
        .inMemWrite       (inMemWrite),
        .inBranch         (inBranch),
        .stall            (stall),
        .outValid         (outValid),
        .addressOrAluData (addressOrAluData),
        .writeData        (writeData),
        .outWriteRegister (outWriteRegister),
        .outRegWrite      (outRegWrite),
        .outMemOrReg      (outMemOrReg),
        .memRead          (memRead),
        .memWrite         (memWrite),
        .outBranch        (outBranch),
        .zeroSignal       (zeroSignal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input alu_op_t op, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        inValid  = v;
        aluOp    = op;
        operandA = a;
        operandB = b;
    endtask

    task automatic edgeSample();
        @(posedge clk);
        #1;
    endtask

    // Runs one mul/div op from first presentation; checks stall length, bubbles and result
    task automatic mdOp(input string tag, input alu_op_t op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp);
        int stallCnt;
        int edges;
        int bubbles;
        stallCnt = 0;
        edges    = 0;
        bubbles  = 0;
        drive(1'b1, op, a, b);
        inRegWrite = 1'b1;
        #1;
        while (stall && edges < 100) begin
            stallCnt++;
            @(posedge clk);
            edges++;
            #1;
            if (!outValid) bubbles++;
        end
        @(posedge clk);
        edges++;
        #1;
        chk({tag, "_stall_cycles"}, 64'(stallCnt), 64'd65);
        chk({tag, "_edges"}, 64'(edges), 64'd66);
        chk({tag, "_bubbles"}, 64'(bubbles), 64'd65);
        chk({tag, "_valid"}, {63'd0, outValid}, 64'd1);
        chk({tag, "_result"}, addressOrAluData, exp);
        chk({tag, "_regwrite"}, {63'd0, outRegWrite}, 64'd1);
    endtask

    initial begin
        compared        = 0;
        mismatched      = 0;
        reset           = 1'b1;
        inValid         = 1'b0;
        aluOp           = ALU_ADD;
        operandA        = 64'd0;
        operandB        = 64'd0;
        inWriteData     = 64'd0;
        inWriteRegister = 6'd0;
        inRegWrite      = 1'b0;
        inMemOrReg      = 1'b0;
        inMemRead       = 1'b0;
        inMemWrite      = 1'b0;
        inBranch        = 1'b0;

        edgeSample();
        edgeSample();
        chk("rst_valid", {63'd0, outValid}, 64'd0);
        chk("rst_data", addressOrAluData, 64'd0);
        chk("rst_zero", {63'd0, zeroSignal}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);

        // ADD 5+7
        drive(1'b1, ALU_ADD, 64'd5, 64'd7);
        reset           = 1'b0;
        inRegWrite      = 1'b1;
        inWriteRegister = 6'd9;
        edgeSample();
        chk("add_data", addressOrAluData, 64'd12);
        chk("add_valid", {63'd0, outValid}, 64'd1);
        chk("add_regwrite", {63'd0, outRegWrite}, 64'd1);
        chk("add_zero", {63'd0, zeroSignal}, 64'd0);
        chk("add_rd", {58'd0, outWriteRegister}, 64'd9);

        // SUB 9-9 as a branch
        drive(1'b1, ALU_SUB, 64'd9, 64'd9);
        inRegWrite = 1'b0;
        inBranch   = 1'b1;
        edgeSample();
        chk("sub_data", addressOrAluData, 64'd0);
        chk("sub_zero", {63'd0, zeroSignal}, 64'd1);
        chk("sub_branch", {63'd0, outBranch}, 64'd1);
        chk("sub_regwrite", {63'd0, outRegWrite}, 64'd0);

        inBranch = 1'b0;
        drive(1'b1, ALU_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        edgeSample();
        chk("slt", addressOrAluData, 64'd1);
        chk("slt_zero", {63'd0, zeroSignal}, 64'd0);

        drive(1'b1, ALU_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        edgeSample();
        chk("sltu", addressOrAluData, 64'd0);
        chk("sltu_zero", {63'd0, zeroSignal}, 64'd1);

        drive(1'b1, ALU_SRA, 64'h8000_0000_0000_0000, 64'd4);
        edgeSample();
        chk("sra", addressOrAluData, 64'hF800_0000_0000_0000);

        drive(1'b1, ALU_SRL, 64'h8000_0000_0000_0000, 64'd4);
        edgeSample();
        chk("srl", addressOrAluData, 64'h0800_0000_0000_0000);

        // Only operandB[5:0] is the shift amount
        drive(1'b1, ALU_SLL, 64'd1, 64'h103);
        edgeSample();
        chk("sll", addressOrAluData, 64'd8);

        drive(1'b1, ALU_AND, 64'hF0F0, 64'h0FF0);
        edgeSample();
        chk("and", addressOrAluData, 64'h00F0);

        drive(1'b1, ALU_XOR, 64'hFF00, 64'h0FF0);
        edgeSample();
        chk("xor", addressOrAluData, 64'hF0F0);

        mdOp("mul", ALU_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
        mdOp("mulhu", ALU_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1);
        mdOp("divu", ALU_DIVU, 64'd100, 64'd7, 64'd14);
        mdOp("remu", ALU_REMU, 64'd100, 64'd7, 64'd2);
        mdOp("divu0", ALU_DIVU, 64'd55, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        mdOp("remu0", ALU_REMU, 64'd123, 64'd0, 64'd123);

        // Reset at BUSY cycle 30 abandons the divide
        drive(1'b1, ALU_DIVU, 64'd1000, 64'd3);
        for (int i = 0; i < 31; i++) edgeSample();
        chk("busy_stall", {63'd0, stall}, 64'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_busy_stall", {63'd0, stall}, 64'd0);
        edgeSample();
        chk("rstbusy_valid", {63'd0, outValid}, 64'd0);
        chk("rstbusy_data", addressOrAluData, 64'd0);
        chk("rstbusy_regwrite", {63'd0, outRegWrite}, 64'd0);
        chk("rstbusy_stall", {63'd0, stall}, 64'd0);
        drive(1'b1, ALU_ADD, 64'd2, 64'd3);
        reset = 1'b0;
        #1;
        chk("post_rst_stall", {63'd0, stall}, 64'd0);
        edgeSample();
        chk("post_rst_add", addressOrAluData, 64'd5);
        chk("post_rst_valid", {63'd0, outValid}, 64'd1);

        // Store with inValid toggling 1,0,1
        drive(1'b1, ALU_ADD, 64'h1000, 64'd8);
        inRegWrite  = 1'b0;
        inMemWrite  = 1'b1;
        inWriteData = 64'hDEAD_BEEF_CAFE_F00D;
        edgeSample();
        chk("st1_valid", {63'd0, outValid}, 64'd1);
        chk("st1_memwrite", {63'd0, memWrite}, 64'd1);
        chk("st1_addr", addressOrAluData, 64'h1008);
        chk("st1_wdata", writeData, 64'hDEAD_BEEF_CAFE_F00D);
        drive(1'b0, ALU_ADD, 64'h3000, 64'd8);
        inWriteData = 64'h1234;
        edgeSample();
        chk("bub_valid", {63'd0, outValid}, 64'd0);
        chk("bub_memwrite", {63'd0, memWrite}, 64'd0);
        chk("bub_wdata_hold", writeData, 64'hDEAD_BEEF_CAFE_F00D);
        chk("bub_addr_hold", addressOrAluData, 64'h1008);
        drive(1'b1, ALU_ADD, 64'h2000, 64'h10);
        inWriteData = 64'h5555_5555_5555_5555;
        edgeSample();
        chk("st2_valid", {63'd0, outValid}, 64'd1);
        chk("st2_memwrite", {63'd0, memWrite}, 64'd1);
        chk("st2_addr", addressOrAluData, 64'h2010);
        chk("st2_wdata", writeData, 64'h5555_5555_5555_5555);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
